sid_reg_if: RTL and testbench
=============================

# sid_reg_if

Host-side register interface that sits directly upstream of the single-voice SID top level and drives its `frequency`, `duration`, `attack`, `sustain` and `waveform` inputs. Each byte write is accepted over a valid/ready handshake into shadow registers. A commit request copies all shadow values to the active outputs atomically, on the next internal sample tick, so the voice never sees a half-updated parameter set.

## Interface

**Parameters**
- `TICK_DIV`, default 16: period of the internal commit tick, in `clk` cycles. Legal range 2..65535.

**Ports**
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  host write request.
- `wr_ready`  out  1  block can accept a write.
- `wr_addr`  in  3  register address.
- `wr_data`  in  8  write data.
- `rd_addr`  in  3  readback address (used only with `SID_REGIF_READBACK_EN`).
- `rd_data`  out  8  readback data.
- `frequency`  out  16  active voice frequency.
- `duration`  out  16  active voice duration.
- `attack`  out  8  active attack.
- `sustain`  out  8  active sustain.
- `waveform`  out  8  active waveform select.
- `commit_busy`  out  1  a commit is pending.
- `committed`  out  1  one-cycle pulse when the active registers update.

## Operation

**Register map** (all registers are shadow registers except CTRL)
- 0: FREQ_LO
- 1: FREQ_HI
- 2: DUR_LO
- 3: DUR_HI
- 4: ATTACK
- 5: SUSTAIN
- 6: WAVEFORM
- 7: CTRL, write-only strobes:
  - bit0 COMMIT
  - bit1 CLEAR
  - bits 7:2 ignored

**Write acceptance**
- A write is accepted on any cycle where `wr_valid && wr_ready`.
- Addresses 0–6: the shadow byte is updated at that edge. Active outputs are unchanged.

**CTRL writes**
- CLEAR: all seven shadow bytes are zeroed at the accepting edge.
- COMMIT: sets the pending flag (state PENDING).
- CLEAR and COMMIT together: clear takes effect first, so zeros are committed.

**FSM**
- IDLE:
  - `wr_ready=1`.
  - An accepted COMMIT moves the FSM to PENDING.
- PENDING:
  - `wr_ready=0` and `commit_busy=1`.
  - On the first tick edge strictly after entry, active outputs are loaded from shadow and `committed` pulses high for one cycle.
  - The FSM then returns to IDLE.

**Tick counter**
- Free-running counter, 0..TICK_DIV-1, wraps to 0.
- `tick` is asserted while the count equals TICK_DIV-1.
- The counter runs from reset regardless of FSM state.

**Boundary conditions**
- **COMMIT accepted on a tick cycle:** that tick is not used. The apply happens on the next tick, TICK_DIV cycles later.
- **Shadow writes during PENDING:** impossible, because `wr_ready=0`. The host must hold `wr_valid` and `wr_addr`/`wr_data` until `wr_ready` returns.
- **Reset mid-PENDING:** the pending commit is discarded; outputs go to 0.

## Timing

**Reset values**
- All active outputs, all shadow bytes and `rd_data`: 0.
- Tick counter: 0.
- `commit_busy`: 0, `committed`: 0, `wr_ready`: 1.
- FSM state: IDLE.

**Commit latency**
- Active outputs change at the same edge where `committed` rises.
- From the COMMIT accept edge, the update lands 1..TICK_DIV cycles later.

**Handshake outputs**
- `wr_ready` is a registered output: it falls in the cycle after COMMIT is accepted and rises in the cycle after `committed` asserts.
- `commit_busy` equals `!wr_ready`.

## Configuration

Feature macro: `SID_REGIF_READBACK_EN`.

**Defined**
- `rd_data` is registered with 1-cycle latency from `rd_addr`.
- Addresses 0–6 return the **active** (not shadow) byte.
- Address 7 returns `{7'b0, commit_busy}`.

**Undefined**
- `rd_data` is tied to 0 and `rd_addr` is ignored.
- No readback mux is synthesized.

## Test plan

- **Reset:** assert `rst_n=0` mid-run -> all outputs 0 and `wr_ready=1` immediately (asynchronously); after release, tick first fires at cycle TICK_DIV-1.
- **Atomic update:** write FREQ_LO=0x34, FREQ_HI=0x12, WAVEFORM=0x10, then CTRL=0x01 -> `frequency` stays 0 until `committed`, then `frequency=0x1234` and `waveform=0x10` at the same edge; `wr_ready` is low throughout PENDING.
- **Commit on tick:** with TICK_DIV=16, accept COMMIT exactly on a tick cycle -> `committed` occurs 16 cycles later, not at that edge.
- **Backpressure:** hold `wr_valid` with ATTACK=0x55 during PENDING -> not accepted until `wr_ready` returns; `attack` output unchanged until the next commit.
- **Clear + commit:** after committing non-zero values, write CTRL=0x03 -> all active outputs become 0 at the next `committed`.
- **Readback** (macro on): after committing DUR=0xBEEF, `rd_addr=3` -> `rd_data=0xBE` one cycle later; `rd_addr=7` during PENDING -> 0x01. With the macro off -> `rd_data=0` always.

Source files
------------

// File: rtl/sid_reg_if.sv
// Host register interface for the single-voice SID: byte writes into shadow registers, committed
// atomically to the active voice outputs on the next internal tick. Optional readback: SID_REGIF_READBACK_EN.
module sid_reg_if #(
  parameter int TICK_DIV = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [2:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [15:0] frequency,
  output logic [15:0] duration,
  output logic [7:0]  attack,
  output logic [7:0]  sustain,
  output logic [7:0]  waveform,
  output logic        commit_busy,
  output logic        committed
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_DONE} state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  state_t          r_state;
  logic [15:0]     r_tick_cnt;
  logic [6:0][7:0] r_shadow;
  logic            r_ready;
  logic            r_committed;
  logic [15:0]     r_freq, r_dur;
  logic [7:0]      r_attack, r_sustain, r_wave;

  logic w_tick, w_accept, w_ctrl;

  assign w_tick   = (r_tick_cnt == TICK_LAST);
  assign w_accept = wr_valid && r_ready;
  assign w_ctrl   = w_accept && (wr_addr == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (w_ctrl && wr_data[1]) begin
      r_shadow <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < 7; i++)
        if (wr_addr == 3'(i)) r_shadow[i] <= wr_data;
    end
  end

  // DONE holds wr_ready low for the committed cycle so ready returns the cycle after the pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_committed <= 1'b0;
      r_freq      <= '0;
      r_dur       <= '0;
      r_attack    <= '0;
      r_sustain   <= '0;
      r_wave      <= '0;
    end else begin
      r_committed <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ctrl && wr_data[0]) begin
            r_state <= S_PEND;
            r_ready <= 1'b0;
          end
        end
        S_PEND: begin
          if (w_tick) begin
            r_freq      <= {r_shadow[1], r_shadow[0]};
            r_dur       <= {r_shadow[3], r_shadow[2]};
            r_attack    <= r_shadow[4];
            r_sustain   <= r_shadow[5];
            r_wave      <= r_shadow[6];
            r_committed <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign wr_ready    = r_ready;
  assign commit_busy = !r_ready;
  assign committed   = r_committed;
  assign frequency   = r_freq;
  assign duration    = r_dur;
  assign attack      = r_attack;
  assign sustain     = r_sustain;
  assign waveform    = r_wave;

`ifdef SID_REGIF_READBACK_EN
  logic [6:0][7:0] w_act;
  logic [7:0]      r_rd;

  assign w_act = {r_wave, r_sustain, r_attack, r_dur[15:8], r_dur[7:0], r_freq[15:8], r_freq[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd <= '0;
    end else begin
      r_rd <= {7'b0, !r_ready};
      for (int i = 0; i < 7; i++)
        if (rd_addr == 3'(i)) r_rd <= w_act[i];
    end
  end

  assign rd_data = r_rd;
`else
  logic w_rd_unused;
  assign w_rd_unused = ^rd_addr;
  assign rd_data     = '0;
`endif

endmodule

// File: tb/tb_sid_reg_if.sv
// Randomized bench for sid_reg_if against a cycle-indexed behavioural model plus directed literal checks.
module tb_sid_reg_if;
  localparam int TD = 16;

  logic        clk = 1'b0, rst_n = 1'b0, wr_valid = 1'b0;
  logic [2:0]  wr_addr = '0, rd_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ready, commit_busy, committed;
  logic [7:0]  rd_data, attack, sustain, waveform;
  logic [15:0] frequency, duration;

  sid_reg_if #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .frequency(frequency), .duration(duration), .attack(attack), .sustain(sustain),
    .waveform(waveform), .commit_busy(commit_busy), .committed(committed)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // model: cycle index since reset release, shadow/active byte arrays, scheduled apply cycle
  int         cyc, m_apply_at;
  bit         m_ready, m_committed, m_pend, last_acc;
  logic [7:0] m_sh[7], m_act[7], m_rd;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_ready = 1; m_committed = 0; m_pend = 0; m_apply_at = -1; m_rd = 0;
    for (int i = 0; i < 7; i++) begin m_sh[i] = 0; m_act[i] = 0; end
  endtask

  task automatic model_edge();
    int  c;
    bit  nxt_ready, nxt_comm;
    c = cyc;
    nxt_ready = m_ready;
`ifdef SID_REGIF_READBACK_EN
    m_rd = (rd_addr == 3'd7) ? {7'b0, !m_ready} : m_act[int'(rd_addr)];
`else
    m_rd = 8'h00;
`endif
    nxt_comm = m_pend && (c == m_apply_at);
    if (nxt_comm) begin
      for (int i = 0; i < 7; i++) m_act[i] = m_sh[i];
      m_pend = 0;
    end
    last_acc = wr_valid && m_ready;
    if (last_acc) begin
      if (wr_addr != 3'd7) m_sh[int'(wr_addr)] = wr_data;
      else begin
        if (wr_data[1]) for (int i = 0; i < 7; i++) m_sh[i] = 0;
        if (wr_data[0]) begin
          m_pend = 1;
          nxt_ready = 0;
          // first cycle strictly after c whose index is TD-1 mod TD
          m_apply_at = c + 1 + (TD - 1 - ((c + 1) % TD));
        end
      end
    end
    if (m_committed) nxt_ready = 1;
    m_ready = nxt_ready;
    m_committed = nxt_comm;
    cyc++;
  endtask

  task automatic compare();
    chk("wr_ready",    32'(wr_ready),    32'(m_ready));
    chk("commit_busy", 32'(commit_busy), 32'(!m_ready));
    chk("committed",   32'(committed),   32'(m_committed));
    chk("frequency",   32'(frequency),   32'({m_act[1], m_act[0]}));
    chk("duration",    32'(duration),    32'({m_act[3], m_act[2]}));
    chk("attack",      32'(attack),      32'(m_act[4]));
    chk("sustain",     32'(sustain),     32'(m_act[5]));
    chk("waveform",    32'(waveform),    32'(m_act[6]));
    chk("rd_data",     32'(rd_data),     32'(m_rd));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    int n;
    wr_valid = 1; wr_addr = a; wr_data = d; n = 0;
    do begin step(); n++; end while (!last_acc && n < 200);
    chk("wr_accept_timeout", 32'(last_acc), 32'd1);
    wr_valid = 0;
  endtask

  task automatic wait_committed(output int n);
    n = 0;
    while (!committed && n < 100) begin step(); n++; end
    chk("commit_timeout", 32'(committed), 32'd1);
  endtask

  int n;

  initial begin
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_freq",  32'(frequency), 32'd0);
    rst_n = 1;
    model_reset();
    step();

    // atomic update
    wr(3'd0, 8'h34); wr(3'd1, 8'h12); wr(3'd6, 8'h10); wr(3'd7, 8'h01);
    n = 0;
    while (!committed && n < 40) begin
      chk("freq_hold", 32'(frequency), 32'd0);
      chk("ready_low", 32'(wr_ready), 32'd0);
      step(); n++;
    end
    chk("freq_commit", 32'(frequency), 32'h1234);
    chk("wave_commit", 32'(waveform), 32'h10);
    chk("ready_low_at_commit", 32'(wr_ready), 32'd0);
    step();
    chk("ready_back", 32'(wr_ready), 32'd1);

    // backpressure: ATTACK write held through PENDING
    wr(3'd7, 8'h01);
    wr(3'd4, 8'h55);
    chk("attack_hold", 32'(attack), 32'd0);
    wr(3'd7, 8'h01);
    wait_committed(n);
    chk("attack_commit", 32'(attack), 32'h55);

    // commit accepted on a tick cycle
    step();
    while (cyc % TD != TD - 1) step();
    wr_valid = 1; wr_addr = 3'd7; wr_data = 8'h01;
    step();
    chk("tick_accept", 32'(last_acc), 32'd1);
    wr_valid = 0;
    wait_committed(n);
    chk("tick_latency", 32'(n), 32'd16);

    // clear + commit
    wr(3'd2, 8'hEF); wr(3'd3, 8'hBE); wr(3'd7, 8'h01);
    wait_committed(n);
    chk("dur_commit", 32'(duration), 32'hBEEF);
`ifdef SID_REGIF_READBACK_EN
    rd_addr = 3'd3; step();
    chk("rd_dur_hi", 32'(rd_data), 32'hBE);
    wr(3'd7, 8'h01);
    rd_addr = 3'd7; step();
    chk("rd_busy", 32'(rd_data), 32'h01);
    wait_committed(n);
`else
    chk("rd_off", 32'(rd_data), 32'd0);
`endif
    wr(3'd7, 8'h03);
    wait_committed(n);
    chk("clr_freq", 32'(frequency), 32'd0);
    chk("clr_dur",  32'(duration), 32'd0);
    chk("clr_att",  32'(attack), 32'd0);
    chk("clr_wave", 32'(waveform), 32'd0);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      rd_addr = 3'($urandom);
      if ($urandom % 4 == 0) begin
        logic [2:0] a;
        a = 3'($urandom);
        wr(a, 8'($urandom));
      end else step();
    end

    // reset mid-PENDING
    wr(3'd0, 8'hA5); wr(3'd7, 8'h01);
    step();
    #2 rst_n = 0;
    #1;
    chk("arst_ready",  32'(wr_ready), 32'd1);
    chk("arst_busy",   32'(commit_busy), 32'd0);
    chk("arst_comm",   32'(committed), 32'd0);
    chk("arst_outs",   32'(frequency | duration | 16'(attack) | 16'(sustain) | 16'(waveform)), 32'd0);
    chk("arst_rd",     32'(rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    wr_valid = 1; wr_addr = 3'd7; wr_data = 8'h01;
    step();
    wr_valid = 0;
    wait_committed(n);
    chk("post_reset_latency", 32'(n), 32'd15);
    chk("post_reset_freq", 32'(frequency), 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
